// File: rtl/strobe_arbiter_if.sv
// strobe_arbiter_if: serialised event port between the strobe arbiter and its
// single consumer.
//   ev_valid  master->slave  an event is offered on ev_chan
//   ev_chan   master->slave  channel index of the offered event
//   ev_ready  slave->master  consumer accepts; handshake = ev_valid & ev_ready
interface strobe_arbiter_if #(
    parameter int N = 4
);
    localparam int CHW = $clog2(N);

    logic           ev_valid;
    logic           ev_ready;
    logic [CHW-1:0] ev_chan;

    modport master (output ev_valid, output ev_chan, input  ev_ready);
    modport slave  (input  ev_valid, input  ev_chan, output ev_ready);
endinterface

// File: rtl/strobe_arbiter.sv
// strobe_arbiter: collects one-clock strobes from N channels into saturating
// pending counters and serialises them onto one valid/ready event port with
// round-robin arbitration (at most one event every two cycles).
//   clk        system clock
//   rst        asynchronous reset, active low
//   enable     0 blocks new offers; counting continues
//   strobe_in  per-channel one-clock strobes
//   ev         event port (master side: ev_valid/ev_chan out, ev_ready in)
//   pend_any   registered OR of all pending counters
//   overflow   sticky per-channel "strobe dropped" flags
//   ovf_clr    clears all overflow flags (a same-cycle set wins)

// Per-channel pending counter with saturation and sticky overflow.
module strobe_lane #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        // Clear first so a set in the same cycle overrides it.
        ovf_d = ovf_clr ? 1'b0 : ovf_q;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            // An offer implies cnt >= 1, so this never wraps.
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

module strobe_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N-1:0]          strobe_in,
    strobe_arbiter_if.master      ev,
    output logic                  pend_any,
    output logic [N-1:0]          overflow,
    input  logic                  ovf_clr
);
    localparam int CHW = $clog2(N);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                   state_q, state_d;
    logic                     ev_valid_q, ev_valid_d;
    logic [CHW-1:0]           ev_chan_q, ev_chan_d;
    logic [CHW-1:0]           last_grant_q, last_grant_d;
    logic                     pend_any_q, pend_any_d;

    logic [N-1:0][CNT_W-1:0]  cnt;
    logic [N-1:0]             nz;
    logic [N-1:0]             dec;
    logic                     handshake;
    logic                     found;
    logic [CHW-1:0]           pick;
    logic [CHW:0]             scan;

    assign handshake = ev_valid_q && ev.ev_ready;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign dec[i] = handshake && (ev_chan_q == CHW'(i));
        assign nz[i]  = |cnt[i];

        strobe_lane #(.CNT_W(CNT_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .inc     (strobe_in[i]),
            .dec     (dec[i]),
            .ovf_clr (ovf_clr),
            .cnt     (cnt[i]),
            .ovf     (overflow[i])
        );
    end

    // Round-robin pick over the registered counts: first nonzero channel
    // starting at last_grant+1, wrapping modulo N (N need not be a power of 2).
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int k = 1; k <= N; k++) begin
            scan = {1'b0, last_grant_q} + (CHW+1)'(k);
            if (scan >= (CHW+1)'(N)) scan = scan - (CHW+1)'(N);
            if (!found && nz[scan[CHW-1:0]]) begin
                found = 1'b1;
                pick  = scan[CHW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ev_valid_d   = ev_valid_q;
        ev_chan_d    = ev_chan_q;
        last_grant_d = last_grant_q;
        pend_any_d   = |nz;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    ev_chan_d  = pick;
                    ev_valid_d = 1'b1;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                // Offer is held regardless of enable until accepted.
                if (handshake) begin
                    last_grant_d = ev_chan_q;
                    ev_valid_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                ev_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ev_valid_q   <= 1'b0;
            ev_chan_q    <= '0;
            last_grant_q <= CHW'(N-1);
            pend_any_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ev_valid_q   <= ev_valid_d;
            ev_chan_q    <= ev_chan_d;
            last_grant_q <= last_grant_d;
            pend_any_q   <= pend_any_d;
        end
    end

    assign ev.ev_valid = ev_valid_q;
    assign ev.ev_chan  = ev_chan_q;
    assign pend_any    = pend_any_q;
endmodule

// File: tb/tb_strobe_arbiter.sv
module tb_strobe_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [N-1:0] strobe_in = '0;
    logic         pend_any;
    logic [N-1:0] overflow;

    strobe_arbiter_if #(.N(N)) ev_if ();

    strobe_arbiter #(.N(N), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .strobe_in (strobe_in),
        .ev        (ev_if.master),
        .pend_any  (pend_any),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [3:0] hs_ch[$];
    int         hs_cyc[$];

    // Handshake monitor: records channel and cycle index of every accept.
    always @(posedge clk) begin
        if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1) begin
            hs_ch.push_back(4'(ev_if.ev_chan));
            hs_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        strobe_in = m;
        @(negedge clk);
        strobe_in = '0;
    endtask

    task automatic clear_hs();
        hs_ch.delete();
        hs_cyc.delete();
    endtask

    // Wait (bounded) for n handshakes, then linger to catch extras.
    task automatic wait_hs(input int n, input int budget);
        int b;
        b = 0;
        while (hs_ch.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        step(6);
    endtask

    function automatic logic [31:0] pack_hs();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < hs_ch.size() && i < 8; i++) p[i*4 +: 4] = hs_ch[i];
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; strobe_in = '1; ev_if.ev_ready = 1'b0;
        step(3);
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ev_if.ev_valid); end
        checks++;
        if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b want 0000", overflow); end
        checks++;
        if (pend_any !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", pend_any); end
        rst = 1'b1;
        @(negedge clk);
        strobe_in = '0;
        @(negedge clk);
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_chan !== 2'd0) begin
            errors++; $display("FAIL reset_first_offer: valid=%b chan=%0d want 1/0", ev_if.ev_valid, ev_if.ev_chan);
        end
        clear_hs();
        ev_if.ev_ready = 1'b1;
        wait_hs(4, 40);
        checks++;
        if (hs_ch.size() !== 4 || pack_hs() !== 32'h3210) begin
            errors++; $display("FAIL reset_drain: n=%0d order=%h want 4/3210", hs_ch.size(), pack_hs());
        end
    endtask

    task automatic test_round_robin();
        clear_hs();
        pulse(4'b1111);
        wait_hs(4, 40);
        checks++;
        if (hs_ch.size() !== 4 || pack_hs() !== 32'h3210) begin
            errors++; $display("FAIL rr_burst1: n=%0d order=%h want 4/3210", hs_ch.size(), pack_hs());
        end
        checks++;
        if (hs_cyc.size() < 4 || hs_cyc[3] - hs_cyc[0] !== 6) begin
            errors++; $display("FAIL rr_spacing: span=%0d want 6", hs_cyc.size() >= 4 ? hs_cyc[3] - hs_cyc[0] : -1);
        end
        clear_hs();
        pulse(4'b1111);
        wait_hs(4, 40);
        checks++;
        if (hs_ch.size() !== 4 || pack_hs() !== 32'h3210) begin
            errors++; $display("FAIL rr_burst2: n=%0d order=%h want 4/3210", hs_ch.size(), pack_hs());
        end
        clear_hs();
        pulse(4'b0010);
        wait_hs(1, 20);
        checks++;
        if (hs_ch.size() !== 1 || pack_hs() !== 32'h1) begin
            errors++; $display("FAIL rr_setup_grant1: n=%0d order=%h want 1/1", hs_ch.size(), pack_hs());
        end
        clear_hs();
        pulse(4'b1111);
        wait_hs(4, 40);
        checks++;
        if (hs_ch.size() !== 4 || pack_hs() !== 32'h1032) begin
            errors++; $display("FAIL rr_from1: n=%0d order=%h want 4/1032", hs_ch.size(), pack_hs());
        end
    endtask

    task automatic test_single();
        int t0;
        clear_hs();
        t0 = cyc;
        strobe_in = 4'b0100;
        @(negedge clk);
        strobe_in = '0;
        @(negedge clk);
        checks++;
        if (pend_any !== 1'b1 || ev_if.ev_valid !== 1'b1 || ev_if.ev_chan !== 2'd2) begin
            errors++; $display("FAIL single_offer: pend=%b valid=%b chan=%0d want 1/1/2", pend_any, ev_if.ev_valid, ev_if.ev_chan);
        end
        wait_hs(1, 20);
        checks++;
        if (hs_ch.size() !== 1 || pack_hs() !== 32'h2 || hs_cyc[0] - t0 !== 2) begin
            errors++; $display("FAIL single_hs: n=%0d order=%h lat=%0d want 1/2/2", hs_ch.size(), pack_hs(), hs_cyc.size() > 0 ? hs_cyc[0] - t0 : -1);
        end
        checks++;
        if (pend_any !== 1'b0) begin errors++; $display("FAIL single_pend_clear: got %b want 0", pend_any); end
    endtask

    task automatic test_back_to_back();
        int bad;
        clear_hs();
        ev_if.ev_ready = 1'b0;
        pulse(4'b0010); pulse(4'b0010); pulse(4'b0010);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ev_if.ev_valid !== 1'b1 || ev_if.ev_chan !== 2'd1) bad++;
        end
        checks++;
        if (bad != 0 || hs_ch.size() !== 0) begin
            errors++; $display("FAIL bp_hold: unstable cycles=%0d hs=%0d want 0/0", bad, hs_ch.size());
        end
        ev_if.ev_ready = 1'b1;
        wait_hs(3, 30);
        checks++;
        if (hs_ch.size() !== 3 || pack_hs() !== 32'h111) begin
            errors++; $display("FAIL bp_drain: n=%0d order=%h want 3/111", hs_ch.size(), pack_hs());
        end
        checks++;
        if (hs_cyc.size() < 3 || hs_cyc[1] - hs_cyc[0] !== 2 || hs_cyc[2] - hs_cyc[1] !== 2) begin
            errors++; $display("FAIL bp_spacing: got %0d/%0d want 2/2",
                hs_cyc.size() >= 2 ? hs_cyc[1] - hs_cyc[0] : -1, hs_cyc.size() >= 3 ? hs_cyc[2] - hs_cyc[1] : -1);
        end
    endtask

    task automatic test_saturation();
        int bad;
        clear_hs();
        ev_if.ev_ready = 1'b0;
        strobe_in = 4'b1000;
        step(17);
        strobe_in = '0;
        step(1);
        checks++;
        if (overflow !== 4'b1000) begin errors++; $display("FAIL sat_ovf_set: got %b want 1000", overflow); end
        ev_if.ev_ready = 1'b1;
        wait_hs(15, 60);
        bad = 0;
        foreach (hs_ch[i]) if (hs_ch[i] !== 4'd3) bad++;
        checks++;
        if (hs_ch.size() !== 15 || bad != 0) begin
            errors++; $display("FAIL sat_drain: n=%0d wrong_chan=%0d want 15/0", hs_ch.size(), bad);
        end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 4'b0000) begin errors++; $display("FAIL sat_ovf_clr: got %b want 0000", overflow); end
        clear_hs();
        ev_if.ev_ready = 1'b0;
        strobe_in = 4'b1000;
        step(15);
        ovf_clr = 1'b1;
        step(1);
        strobe_in = '0;
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 4'b1000) begin errors++; $display("FAIL sat_set_beats_clr: got %b want 1000", overflow); end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        ev_if.ev_ready = 1'b1;
        wait_hs(15, 60);
        checks++;
        if (hs_ch.size() !== 15) begin errors++; $display("FAIL sat_drain2: n=%0d want 15", hs_ch.size()); end
    endtask

    task automatic test_enable();
        clear_hs();
        enable = 1'b0;
        ev_if.ev_ready = 1'b1;
        pulse(4'b0001); pulse(4'b0010); pulse(4'b0001);
        step(10);
        checks++;
        if (hs_ch.size() !== 0 || ev_if.ev_valid !== 1'b0 || pend_any !== 1'b1) begin
            errors++; $display("FAIL en_block: hs=%0d valid=%b pend=%b want 0/0/1", hs_ch.size(), ev_if.ev_valid, pend_any);
        end
        enable = 1'b1;
        wait_hs(3, 30);
        checks++;
        if (hs_ch.size() !== 3 || pack_hs() !== 32'h010) begin
            errors++; $display("FAIL en_release: n=%0d order=%h want 3/010", hs_ch.size(), pack_hs());
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        clear_hs();
        ev_if.ev_ready = 1'b1;
        t0 = cyc;
        strobe_in = 4'b0001;
        @(negedge clk);
        strobe_in = '0;
        @(negedge clk);
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_chan !== 2'd0) begin
            errors++; $display("FAIL sim_offer: valid=%b chan=%0d want 1/0", ev_if.ev_valid, ev_if.ev_chan);
        end
        strobe_in = 4'b0001;
        @(negedge clk);
        strobe_in = '0;
        wait_hs(2, 20);
        checks++;
        if (hs_ch.size() !== 2 || pack_hs() !== 32'h00 || hs_cyc[0] - t0 !== 2 || hs_cyc[1] - t0 !== 4) begin
            errors++; $display("FAIL sim_inc_dec: n=%0d order=%h want 2 events at +2,+4", hs_ch.size(), pack_hs());
        end
    endtask

    task automatic test_async_reset();
        clear_hs();
        ev_if.ev_ready = 1'b0;
        pulse(4'b0100);
        step(2);
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_chan !== 2'd2) begin
            errors++; $display("FAIL ar_offer: valid=%b chan=%0d want 1/2", ev_if.ev_valid, ev_if.ev_chan);
        end
        #2;
        rst = 1'b0;
        ev_if.ev_ready = 1'b1;
        #1;
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL ar_drop: valid=%b want 0", ev_if.ev_valid); end
        step(3);
        rst = 1'b1;
        step(6);
        checks++;
        if (hs_ch.size() !== 0 || ev_if.ev_valid !== 1'b0 || pend_any !== 1'b0) begin
            errors++; $display("FAIL ar_after: hs=%0d valid=%b pend=%b want 0/0/0", hs_ch.size(), ev_if.ev_valid, pend_any);
        end
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_back_to_back();
        test_saturation();
        test_enable();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/strobe_arbiter.md
Name: strobe_arbiter

Overview:
- Collects one-clock strobes from N strobe_gen channels, each typically driven by a frqdivmod divider.
- Counts pending strobes per channel so that none are lost.
- Serialises the strobes onto a single event port with a valid/ready handshake, using round-robin arbitration.
- Sits between the strobe generators and a single shared consumer, such as an envelope or sequencer engine.

Parameters:
- N, 4, number of strobe channels (2..16).
- CNT_W, 4, width of each pending counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst  in  1  asynchronous reset, active-low: asserted when 0, released synchronously by the design's reset bridge.
- enable  in  1  when 0, no new events are offered; counting continues.
- strobe_in  in  N  one-clock pulses; bit i belongs to channel i.
- ev_valid  out  1  an event is offered on ev_chan.
- ev_ready  in  1  consumer accepts; a handshake occurs on a cycle where ev_valid and ev_ready are both 1.
- ev_chan  out  clog2(N)  index of the offered channel.
- pend_any  out  1  at least one pending counter is nonzero (registered).
- overflow  out  N  sticky; bit i sets when a strobe on channel i is dropped.
- ovf_clr  in  1  clears all overflow bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - all pend_cnt = 0, ev_valid = 0, ev_chan = 0, pend_any = 0, overflow = 0.
  - State = IDLE, last_grant = N-1, so channel 0 has first priority.
  - Reset mid-offer drops the offer and all pending counts; no handshake is reported.
- Pending counters, per channel i, per cycle:
  - inc = strobe_in[i].
  - dec = handshake && ev_chan==i.
  - inc and dec together: counter unchanged.
  - inc only: +1; if the counter is already at max, it holds and overflow[i] is set.
  - dec only: -1. dec never occurs while the counter is 0, because an offer implies count ≥ 1.
- overflow: ovf_clr clears all bits. If a set and a clear hit the same bit in the same cycle, the set wins.
- FSM state IDLE (ev_valid=0):
  - If enable=1 and any registered pend_cnt is nonzero, pick the first nonzero channel scanning last_grant+1, +2, … modulo N.
  - Register that channel into ev_chan, set ev_valid=1, go to OFFER.
  - Otherwise stay in IDLE.
- FSM state OFFER:
  - ev_valid=1 and ev_chan stay stable until a handshake.
  - On handshake: decrement that counter, last_grant ← ev_chan, ev_valid ← 0, go to IDLE.
  - Deasserting enable during OFFER does not withdraw the offer.
- Throughput and latency:
  - At most one event per 2 cycles.
  - A strobe at cycle t with idle arbiter and ev_ready=1 gives pend_cnt=1 at t+1, ev_valid=1 at t+2, and the handshake at t+2.
- pend_any: registered OR of counters, updated one cycle after the counters.
- Arbitration uses the registered counts, so a strobe arriving during the IDLE decision cycle waits for the next round.
- ev_ready while ev_valid=0 is ignored.

Test Plan:
- Reset check: hold rst=0 with strobe_in all 1s → ev_valid=0, overflow=0, pend_any=0. Release rst → the first offer is ev_chan=0 two cycles later.
- Single strobe: strobe_in=4'b0100 for one cycle, ev_ready=1 → exactly one handshake, with ev_chan=2, 2 cycles after the strobe. pend_any returns to 0.
- Round-robin order: strobe_in=4'b1111 for one cycle, ev_ready=1 → handshake order 0,1,2,3, then a second burst gives 0,1,2,3 again, no channel repeated. Repeat with last_grant=1 → order 2,3,0,1.
- Backpressure: 3 strobes on channel 1, ev_ready=0 for 20 cycles → ev_valid=1, ev_chan=1 stable. Then ev_ready=1 → exactly 3 handshakes on channel 1, 2 cycles apart.
- Saturation and overflow: with CNT_W=4 and ev_ready=0, send 17 strobes on channel 3 → overflow[3]=1, count held at 15. Release → exactly 15 events. ovf_clr → overflow=0. ovf_clr coinciding with a new overflow → the bit stays 1.
- Enable and simultaneous update: enable=0 with strobes → no offers, counts accumulate. A strobe on channel 0 in the same cycle as a channel-0 handshake → count unchanged. Apply rst=0 mid-OFFER → ev_valid drops immediately (asynchronously).
